// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the dm arbiter: FSM state encoding, port indices
// and a small one-hot helper.
package dm_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    function automatic logic [1:0] port_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dm_arb_rr.sv
// Combinational two-way round-robin picker: a lone requester wins outright,
// a tie goes to the port that was not served last.
module dm_arb_rr
    import dm_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_idx
);

    always_comb begin
        grant_valid = |req;
        grant_idx   = PORT_CPU;
        if (&req)
            grant_idx = ~last_grant;
        else if (req[1])
            grant_idx = PORT_DMA;
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter in front of the single-ported data memory.
// Optional access timeout is enabled by defining DM_ARB_TIMEOUT_EN.
module dm_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic [DATA_W-1:0] rdata0,
    output logic              ack0,
    output logic              err0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic [DATA_W-1:0] rdata1,
    output logic              ack1,
    output logic              err1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);
    import dm_arbiter_pkg::*;

    state_t state;
    logic   gnt;
    logic   last_grant;
    logic   grant_valid;
    logic   grant_idx;
    logic   timeout_hit;

    dm_arb_rr u_rr (
        .req         ({req1, req0}),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

`ifdef DM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt;

    // cnt is 0 in the first strobe cycle, so the give-up decision lands on the
    // TIMEOUT_CYCLES-th strobe cycle and the ack follows one edge later.
    always_ff @(posedge clk) begin
        if (rst || state != ACCESS)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign timeout_hit = (state == ACCESS) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gnt        <= PORT_CPU;
            last_grant <= PORT_DMA;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            err0 <= 1'b0;
            err1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        gnt   <= grant_idx;
                        state <= ACCESS;
                        if (grant_idx == PORT_DMA) begin
                            mem_addr  <= addr1;
                            mem_wdata <= wdata1;
                            mem_rd    <= ~we1;
                            mem_wr    <= we1;
                        end else begin
                            mem_addr  <= addr0;
                            mem_wdata <= wdata0;
                            mem_rd    <= ~we0;
                            mem_wr    <= we0;
                        end
                    end
                end
                ACCESS: begin
                    // err mirrors a missing ready, which only a timeout can produce
                    if (mem_ready || timeout_hit) begin
                        mem_rd     <= 1'b0;
                        mem_wr     <= 1'b0;
                        last_grant <= gnt;
                        state      <= DONE;
                        if (gnt == PORT_DMA) begin
                            ack1 <= 1'b1;
                            err1 <= ~mem_ready;
                            if (!mem_ready)
                                rdata1 <= '0;
                            else if (mem_rd)
                                rdata1 <= mem_rdata;
                        end else begin
                            ack0 <= 1'b1;
                            err0 <= ~mem_ready;
                            if (!mem_ready)
                                rdata0 <= '0;
                            else if (mem_rd)
                                rdata0 <= mem_rdata;
                        end
                    end
                end
                DONE: begin
                    // dm drops ready one edge after the strobe; granting earlier
                    // would see the previous access's ready.
                    if (!mem_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios plus a randomized two-requester run
// scored against a transaction-level model of the arbiter and the memory.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic [31:0] rdata0, rdata1;
    logic        ack0, err0, ack1, err1;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rd, mem_wr;
    logic        mem_ready = 1'b0;
    logic        stall = 1'b0;

    logic [31:0] dmem    [0:127];
    logic [31:0] ref_mem [0:127];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dm_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .rdata0(rdata0), .ack0(ack0), .err0(err0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .rdata1(rdata1), .ack1(ack1), .err1(err1),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    // dm stand-in: registered ready follows the strobe by one edge
    always @(posedge clk) begin
        mem_ready <= stall ? 1'b0 : (mem_rd | mem_wr);
        if (mem_wr) dmem[mem_addr[8:2]] <= mem_wdata;
    end
    assign mem_rdata = dmem[mem_addr[8:2]];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (3) tick();
        total++;
        if ({mem_rd, mem_wr, ack0, ack1, err0, err1} !== 6'b0) begin
            bad++; $display("FAIL reset_ctl got=%b want=000000", {mem_rd, mem_wr, ack0, ack1, err0, err1});
        end
        total++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            bad++; $display("FAIL reset_mem got addr=%h wdata=%h want 0", mem_addr, mem_wdata);
        end
        total++;
        if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
            bad++; $display("FAIL reset_rdata got %h/%h want 0", rdata0, rdata1);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_read;
        logic [7:0] rd_h, a0_h;
        logic       a1_any = 1'b0;
        logic [31:0] got = '0;
        rd_h = '0; a0_h = '0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40;
        for (int c = 1; c <= 6; c++) begin
            tick();
            rd_h[c] = mem_rd;
            a0_h[c] = ack0;
            a1_any |= ack1;
            if (ack0) begin req0 = 1'b0; got = rdata0; end
        end
        total++;
        if (rd_h[3:1] !== 3'b011) begin
            bad++; $display("FAIL read_strobe got cyc3..1=%b want 011", rd_h[3:1]);
        end
        total++;
        if (a0_h[5:1] !== 5'b00100) begin
            bad++; $display("FAIL read_ack_cycle got cyc5..1=%b want 00100", a0_h[5:1]);
        end
        total++;
        if (got !== 32'hDEADBEEF) begin
            bad++; $display("FAIL read_data got=%h want=deadbeef", got);
        end
        total++;
        if (a1_any !== 1'b0) begin
            bad++; $display("FAIL read_ack1_quiet got=%b want=0", a1_any);
        end
        req0 = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_write_read;
        logic [7:0] wr_h, a1_h;
        logic       a0_any = 1'b0;
        logic       seen = 1'b0;
        wr_h = '0; a1_h = '0;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h44; wdata1 = 32'h12345678;
        for (int c = 1; c <= 6; c++) begin
            tick();
            wr_h[c] = mem_wr;
            a1_h[c] = ack1;
            a0_any |= ack0;
            if (ack1) req1 = 1'b0;
        end
        ref_mem[17] = 32'h12345678;
        total++;
        if (wr_h[6:1] !== 6'b000011) begin
            bad++; $display("FAIL write_strobe got cyc6..1=%b want 000011", wr_h[6:1]);
        end
        total++;
        if (a1_h[5:1] !== 5'b00100 || a0_any) begin
            bad++; $display("FAIL write_ack got ack1 cyc5..1=%b ack0_any=%b want 00100/0", a1_h[5:1], a0_any);
        end
        req1 = 1'b1; we1 = 1'b0; wdata1 = '0;
        for (int c = 0; c < 12 && !seen; c++) begin
            tick();
            if (ack1) begin
                seen = 1'b1;
                req1 = 1'b0;
                total++;
                if (rdata1 !== 32'h12345678) begin
                    bad++; $display("FAIL readback got=%h want=12345678", rdata1);
                end
            end
        end
        if (!seen) begin
            total++; bad++; $display("FAIL readback_timeout got no ack1 want ack within 12 cycles");
        end
        req1 = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_stale_ready;
        int acks = 0;
        int ackc = -10;
        logic stale = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (ack0) begin acks++; ackc = c; end
            if (c == ackc + 1) req0 = 1'b0;
            if (c >= ackc && c <= ackc + 4 && (mem_rd | mem_wr)) stale = 1'b1;
        end
        total++;
        if (acks != 1) begin
            bad++; $display("FAIL stale_acks got=%0d want=1", acks);
        end
        total++;
        if (stale) begin
            bad++; $display("FAIL stale_strobe got strobe after ack want none");
        end
        req0 = 1'b0;
        repeat (2) tick();
    endtask

`ifdef DM_ARB_TIMEOUT_EN
    task automatic test_timeout;
        int rise = -1;
        int ackc = -1;
        logic a1_any = 1'b0;
        logic e = 1'b0;
        logic [31:0] rd = 32'hFFFF_FFFF;
        stall = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40;
        for (int c = 1; c <= 40 && ackc < 0; c++) begin
            tick();
            if (mem_rd && rise < 0) rise = c;
            a1_any |= ack1;
            if (ack0) begin ackc = c; e = err0; rd = rdata0; req0 = 1'b0; end
        end
        total++;
        if (ackc - rise != 16) begin
            bad++; $display("FAIL timeout_latency got=%0d want=16", ackc - rise);
        end
        total++;
        if (e !== 1'b1 || rd !== 32'h0 || a1_any) begin
            bad++; $display("FAIL timeout_flags got err=%b rdata=%h ack1=%b want 1/0/0", e, rd, a1_any);
        end
        req0 = 1'b0;
        stall = 1'b0;
        repeat (4) tick();
    endtask
`endif

    task automatic test_fairness;
        int order[$];
        int ackc[$];
        int cd0 = 0, cd1 = 0, c = 0;
        do_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h44;
        while (order.size() < 6 && c < 80) begin
            tick(); c++;
            if (ack0 && ack1) begin
                total++; bad++; $display("FAIL fair_dual_ack got both acks want one");
            end
            if (ack0) begin order.push_back(0); ackc.push_back(c); req0 = 1'b0; cd0 = 2; end
            else if (!req0) begin cd0--; if (cd0 <= 0) req0 = 1'b1; end
            if (ack1) begin order.push_back(1); ackc.push_back(c); req1 = 1'b0; cd1 = 2; end
            else if (!req1) begin cd1--; if (cd1 <= 0) req1 = 1'b1; end
        end
        req0 = 1'b0; req1 = 1'b0;
        total++;
        if (order.size() != 6) begin
            bad++; $display("FAIL fair_count got=%0d want=6", order.size());
        end
        for (int i = 0; i < order.size(); i++) begin
            total++;
            if (order[i] != i % 2) begin
                bad++; $display("FAIL fair_order[%0d] got=%0d want=%0d", i, order[i], i % 2);
            end
            if (i > 0) begin
                total++;
                if (ackc[i] - ackc[i-1] != 5) begin
                    bad++; $display("FAIL fair_gap[%0d] got=%0d want=5", i, ackc[i] - ackc[i-1]);
                end
            end
        end
        repeat (12) tick();
    endtask

    task automatic test_reset_mid;
        logic any_ack = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40;
        tick();
        total++;
        if (mem_rd !== 1'b1) begin
            bad++; $display("FAIL midrst_pre got mem_rd=%b want=1", mem_rd);
        end
        tick();
        rst = 1'b1; req0 = 1'b0;
        tick();
        total++;
        if ({mem_rd, mem_wr, ack0, ack1} !== 4'b0) begin
            bad++; $display("FAIL midrst_abort got rd/wr/ack0/ack1=%b want 0000", {mem_rd, mem_wr, ack0, ack1});
        end
        rst = 1'b0;
        repeat (4) begin tick(); any_ack |= ack0 | ack1; end
        total++;
        if (any_ack) begin
            bad++; $display("FAIL midrst_ack got ack after reset want none");
        end
        // A fresh tie right after reset must go to port 0 with a one-cycle grant.
        req0 = 1'b1; req1 = 1'b1; addr0 = 32'h48; addr1 = 32'h4C; we0 = 1'b0; we1 = 1'b0;
        tick();
        total++;
        if (mem_rd !== 1'b1 || mem_addr !== 32'h48) begin
            bad++; $display("FAIL midrst_idle got rd=%b addr=%h want 1/00000048", mem_rd, mem_addr);
        end
        req0 = 1'b0; req1 = 1'b0;
        do_reset();
        tick();
    endtask

    task automatic test_random;
        logic       model_last = 1'b1;
        logic [1:0] pr;
        logic       prev_strobe = 1'b0;
        logic       busy = 1'b0;
        logic       inflight = 1'b0;
        logic       iw;
        logic [31:0] ia, id;
        logic [31:0] keep0, keep1;
        int rise = 0, c = 0;
        int cd0 = 0, cd1 = 0, age0 = 0, age1 = 0;
        bit stop = 1'b0;
        keep0 = rdata0; keep1 = rdata1;
        iw = 1'b0; ia = '0; id = '0;
        while (c < 3000 && (!stop || busy || req0 || req1)) begin
            pr = {req1, req0};
            tick(); c++;
            if (c >= 2800) stop = 1'b1;
            if (mem_rd && mem_wr) begin
                total++; bad++; $display("FAIL rnd_both_strobes cycle=%0d", c);
            end
            if ((mem_rd | mem_wr) && !prev_strobe) begin
                total++;
                if (busy || pr == 2'b00) begin
                    bad++; $display("FAIL rnd_grant_spurious cycle=%0d req=%b busy=%b", c, pr, busy);
                end
                inflight = (pr == 2'b11) ? ~model_last : pr[1];
                iw = inflight ? we1 : we0;
                ia = inflight ? addr1 : addr0;
                id = inflight ? wdata1 : wdata0;
                total++;
                if (mem_addr !== ia || mem_wr !== iw || (iw && mem_wdata !== id)) begin
                    bad++; $display("FAIL rnd_grant port=%0d got addr=%h wr=%b wd=%h want %h/%b/%h",
                                    inflight, mem_addr, mem_wr, mem_wdata, ia, iw, id);
                end
                busy = 1'b1; rise = c;
            end
            prev_strobe = mem_rd | mem_wr;
            if (ack0 || ack1) begin
                total++;
                if (!busy || {ack1, ack0} !== (inflight ? 2'b10 : 2'b01) || c != rise + 2) begin
                    bad++; $display("FAIL rnd_ack cycle=%0d got acks=%b lat=%0d want port=%0d lat=2",
                                    c, {ack1, ack0}, c - rise, inflight);
                end
                total++;
                if (err0 || err1) begin
                    bad++; $display("FAIL rnd_err got=%b%b want=00", err1, err0);
                end
                if (iw) begin
                    ref_mem[ia[8:2]] = id;
                    total++;
                    if ((inflight ? rdata1 : rdata0) !== (inflight ? keep1 : keep0)) begin
                        bad++; $display("FAIL rnd_wr_rdata port=%0d got=%h want=%h", inflight,
                                        inflight ? rdata1 : rdata0, inflight ? keep1 : keep0);
                    end
                end else begin
                    total++;
                    if ((inflight ? rdata1 : rdata0) !== ref_mem[ia[8:2]]) begin
                        bad++; $display("FAIL rnd_rd_data port=%0d addr=%h got=%h want=%h", inflight, ia,
                                        inflight ? rdata1 : rdata0, ref_mem[ia[8:2]]);
                    end
                    if (inflight) keep1 = ref_mem[ia[8:2]]; else keep0 = ref_mem[ia[8:2]];
                end
                model_last = inflight;
                busy = 1'b0;
                if (inflight) begin req1 = 1'b0; cd1 = 2; end else begin req0 = 1'b0; cd0 = 2; end
            end
            if (busy && c > rise + 10) begin
                total++; bad++; $display("FAIL rnd_hang port=%0d no ack after 10 cycles", inflight);
                busy = 1'b0;
            end
            age0 = req0 ? age0 + 1 : 0;
            age1 = req1 ? age1 + 1 : 0;
            if (age0 > 30 || age1 > 30) begin
                total++; bad++; $display("FAIL rnd_starve age0=%0d age1=%0d want <=30", age0, age1);
                age0 = 0; age1 = 0;
            end
            if (!req0) begin
                if (cd0 > 0) cd0--;
                else if (!stop && $urandom_range(0, 3) == 0) begin
                    req0 = 1'b1; we0 = $urandom_range(0, 1) == 1;
                    addr0 = 32'($urandom_range(0, 7)) << 2; wdata0 = $urandom;
                end
            end
            if (!req1) begin
                if (cd1 > 0) cd1--;
                else if (!stop && $urandom_range(0, 3) == 0) begin
                    req1 = 1'b1; we1 = $urandom_range(0, 1) == 1;
                    addr1 = 32'($urandom_range(0, 7)) << 2; wdata1 = $urandom;
                end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (5) tick();
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            dmem[i]    = 32'hA5000000 + 32'(i);
            ref_mem[i] = 32'hA5000000 + 32'(i);
        end
        dmem[16]    = 32'hDEADBEEF;
        ref_mem[16] = 32'hDEADBEEF;
        test_reset();
        test_single_read();
        test_write_read();
        test_stale_ready();
`ifdef DM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_fairness();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
